// File: rtl/camo_key_bank.sv
// Key-configurable camouflage cell bank: per-channel pass/invert/CONST1/CONST0 cells
// driven by an active key that is loaded serially, length-checked, committed and optionally locked.
module camo_key_bank #(
  parameter int NCH     = 5,
  parameter bit OUT_REG = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] data_in,
  output logic [NCH-1:0] data_out,
  input  logic           key_in,
  input  logic           key_shift,
  input  logic           key_commit,
  input  logic           key_lock,
  output logic           commit_ok,
  output logic           key_err,
  output logic [1:0]     key_state
);

  localparam int KL = 2 * NCH;
  localparam int CW = $clog2(KL + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(KL);
  localparam logic [CW-1:0] CNT_SAT  = CW'(KL + 1);

  typedef enum logic [1:0] {
    UNKEYED = 2'b00,
    LOADING = 2'b01,
    KEYED   = 2'b10,
    LOCKED  = 2'b11
  } state_t;

  state_t         r_state;
  logic [KL-1:0]  r_shadow;
  logic [KL-1:0]  r_active;
  logic [CW-1:0]  r_cnt;
  logic           r_has_key;
  logic           r_commit_ok;
  logic           r_key_err;
  logic [NCH-1:0] w_cell;

  function automatic logic [NCH-1:0] cell_map(input logic [KL-1:0] key,
                                              input logic [NCH-1:0] din);
    logic [NCH-1:0] res;
    res = '0;
    for (int i = 0; i < NCH; i++) begin
      case ({key[2*i+1], key[2*i]})
        2'b00:   res[i] = din[i];
        2'b10:   res[i] = ~din[i];
        2'b01:   res[i] = 1'b1;
        default: res[i] = 1'b0;
      endcase
    end
    return res;
  endfunction

  assign w_cell = cell_map(r_active, data_in);

  // Key store and state: commit takes priority over a same-cycle shift and sees the pre-shift count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= UNKEYED;
      r_shadow    <= '0;
      r_active    <= '0;
      r_cnt       <= '0;
      r_has_key   <= 1'b0;
      r_commit_ok <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      r_commit_ok <= 1'b0;
      r_key_err   <= 1'b0;
      if (r_state == LOCKED) begin
        r_key_err <= key_shift | key_commit;
      end else if (key_commit) begin
        r_cnt <= '0;
        if (r_cnt == CNT_FULL) begin
          r_active    <= r_shadow;
          r_commit_ok <= 1'b1;
          r_has_key   <= 1'b1;
          r_state     <= key_lock ? LOCKED : KEYED;
        end else begin
          r_key_err <= 1'b1;
          r_state   <= r_has_key ? KEYED : UNKEYED;
        end
      end else if (key_shift) begin
        r_shadow <= {key_in, r_shadow[KL-1:1]};
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
        r_state <= LOADING;
      end
    end
  end

  // Output stage: optional register between the cells and data_out.
  generate
    if (OUT_REG) begin : g_oreg
      logic [NCH-1:0] r_data_out_p1;
      always_ff @(posedge clk) begin
        if (rst) r_data_out_p1 <= '0;
        else     r_data_out_p1 <= w_cell;
      end
      assign data_out = r_data_out_p1;
    end else begin : g_comb
      assign data_out = w_cell;
    end
  endgenerate

  assign commit_ok = r_commit_ok;
  assign key_err   = r_key_err;
  assign key_state = r_state;

endmodule
